// File: rtl/mac_array_ctrl.sv
// ============================================================================
// Module   : mac_array_ctrl
// Purpose  : Tile-pass sequencer for the systolic MAC array. Each accepted
//            start runs a weight load, a short gap, an activation execute
//            phase and a drain. It drives the weight/activation SRAM read
//            strobes and addresses and a per-row 3-bit instruction bus that
//            is skewed by one cycle per row.
// Options  : MAC_CTRL_PERF_CNT_EN - when defined, perf_cnt counts EXEC
//            cycles (saturating); otherwise perf_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_array_ctrl #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    cfg_w_base,
    input  logic [ADDR_W-1:0]    cfg_a_base,
    input  logic [LEN_W-1:0]     cfg_a_len,
    output logic                 w_cen,
    output logic [ADDR_W-1:0]    w_addr,
    output logic                 a_cen,
    output logic [ADDR_W-1:0]    a_addr,
    output logic [3*ROW-1:0]     inst_row,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          perf_cnt
);

    // One phase counter serves LOAD, EXEC and DRAIN; size it for the longest.
    localparam int C_DRAIN_W = $clog2(ROW + COL + 1);
    localparam int CNT_W     = (LEN_W > C_DRAIN_W) ? LEN_W : C_DRAIN_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [ADDR_W-1:0]  r_a_addr;
    logic [ADDR_W-1:0]  r_a_base;
    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_skew [ROW];

    logic               w_start_acc;
    logic               w_last_load;
    logic               w_last_exec;
    logic               w_last_drain;

    // A start only counts in IDLE and never in the same cycle as an abort.
    assign w_start_acc  = (r_state == S_IDLE) && start && !abort;
    assign w_last_load  = (r_cnt == CNT_W'(COL - 1));
    assign w_last_exec  = (r_cnt == (CNT_W'(r_len) - CNT_W'(1)));
    assign w_last_drain = (r_cnt == CNT_W'(ROW + COL - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)        w_state_nxt = S_LOAD;
                S_LOAD:  if (w_last_load)  w_state_nxt = S_GAP;
                S_GAP:   w_state_nxt = (r_len == '0) ? S_DRAIN : S_EXEC;
                S_EXEC:  if (w_last_exec)  w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_last_drain) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs: strobes, busy and the done pulse.
    always_comb begin
        w_cen = 1'b1;
        a_cen = 1'b1;
        busy  = 1'b1;
        done  = 1'b0;
        case (r_state)
            S_IDLE:  busy  = 1'b0;
            S_LOAD:  w_cen = 1'b0;
            S_EXEC:  a_cen = 1'b0;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    // Phase counter restarts on every state change and idles at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Configuration capture; later cfg_* changes do not affect the pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_base <= '0;
            r_len    <= '0;
        end else if (w_start_acc) begin
            r_a_base <= cfg_a_base;
            r_len    <= cfg_a_len;
        end
    end

    // Weight address: loaded on start, stepped on every LOAD cycle (wraps).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_addr <= '0;
        end else if (w_start_acc) begin
            r_w_addr <= cfg_w_base;
        end else if (r_state == S_LOAD && !abort) begin
            r_w_addr <= r_w_addr + ADDR_W'(1);
        end
    end

    // Activation address: loaded in GAP, stepped on every EXEC cycle (wraps).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_addr <= '0;
        end else if (abort) begin
            r_a_addr <= r_a_addr;
        end else if (r_state == S_GAP) begin
            r_a_addr <= r_a_base;
        end else if (r_state == S_EXEC) begin
            r_a_addr <= r_a_addr + ADDR_W'(1);
        end
    end

    assign w_addr = r_w_addr;
    assign a_addr = r_a_addr;

    // Row 0 instruction lands one cycle after the SRAM strobe (read latency).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skew[0] <= 3'b000;
        end else if (abort) begin
            r_skew[0] <= 3'b000;
        end else begin
            r_skew[0] <= {1'b0, (r_state == S_EXEC), (r_state == S_LOAD)};
        end
    end

    // Each further row sees the previous row's instruction one cycle later.
    generate
        for (genvar gr = 1; gr < ROW; gr++) begin : g_skew
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_skew[gr] <= 3'b000;
                end else if (abort) begin
                    r_skew[gr] <= 3'b000;
                end else begin
                    r_skew[gr] <= r_skew[gr-1];
                end
            end
        end
    endgenerate

    generate
        for (genvar go = 0; go < ROW; go++) begin : g_inst_out
            assign inst_row[3*go +: 3] = r_skew[go];
        end
    endgenerate

`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0] r_perf;

    // Execute-cycle counter: saturates, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf <= '0;
        end else if ((r_state == S_EXEC) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cnt = r_perf;
`else
    assign perf_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
// ============================================================================
// Module   : tb_mac_array_ctrl
// Purpose  : Directed self-checking bench for mac_array_ctrl. Expected
//            outputs are derived per cycle from closed-form pass timing
//            relative to the start-acceptance edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_array_ctrl;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 8;

`ifdef MAC_CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   cfg_w_base;
    logic [ADDR_W-1:0]   cfg_a_base;
    logic [LEN_W-1:0]    cfg_a_len;
    logic                w_cen;
    logic [ADDR_W-1:0]   w_addr;
    logic                a_cen;
    logic [ADDR_W-1:0]   a_addr;
    logic [3*ROW-1:0]    inst_row;
    logic                busy;
    logic                done;
    logic [31:0]         perf_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    bit hold_start = 1'b0;
    int exp_perf   = 0;

    mac_array_ctrl #(
        .ROW    (ROW),
        .COL    (COL),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_w_base (cfg_w_base),
        .cfg_a_base (cfg_a_base),
        .cfg_a_len  (cfg_a_len),
        .w_cen      (w_cen),
        .w_addr     (w_addr),
        .a_cen      (a_cen),
        .a_addr     (a_addr),
        .inst_row   (inst_row),
        .busy       (busy),
        .done       (done),
        .perf_cnt   (perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string where);
        check({where, " w_cen"},    32'(w_cen),    32'd1);
        check({where, " a_cen"},    32'(a_cen),    32'd1);
        check({where, " w_addr"},   32'(w_addr),   32'd0);
        check({where, " a_addr"},   32'(a_addr),   32'd0);
        check({where, " inst_row"}, 32'(inst_row), 32'd0);
        check({where, " busy"},     32'(busy),     32'd0);
        check({where, " done"},     32'(done),     32'd0);
        check({where, " perf_cnt"}, perf_cnt,      32'd0);
    endtask

    // Expected outputs t cycles after the start-acceptance edge.
    task automatic check_cycle(input int t, input int wb, input int ab, input int len);
        int                 endt;
        logic               e_wcen;
        logic               e_acen;
        logic [3*ROW-1:0]   e_inst;
        logic [ADDR_W-1:0]  e_addr;
        endt   = COL + 1 + len + ROW + COL + 1;
        e_wcen = !(t >= 1 && t <= COL);
        e_acen = !(t >= COL + 2 && t <= COL + 1 + len);
        e_inst = '0;
        for (int r = 0; r < ROW; r++) begin
            e_inst[3*r]   = (t >= 2 + r) && (t <= COL + 1 + r);
            e_inst[3*r+1] = (t >= COL + 3 + r) && (t <= COL + 2 + len + r);
        end
        check($sformatf("w_cen t=%0d", t),    32'(w_cen),    32'(e_wcen));
        check($sformatf("a_cen t=%0d", t),    32'(a_cen),    32'(e_acen));
        check($sformatf("busy t=%0d", t),     32'(busy),     32'(t >= 1 && t <= endt));
        check($sformatf("done t=%0d", t),     32'(done),     32'(t == endt));
        check($sformatf("inst_row t=%0d", t), 32'(inst_row), 32'(e_inst));
        if (!e_wcen) begin
            e_addr = ADDR_W'(wb + t - 1);
            check($sformatf("w_addr t=%0d", t), 32'(w_addr), 32'(e_addr));
        end
        if (!e_acen) begin
            e_addr = ADDR_W'(ab + t - (COL + 2));
            check($sformatf("a_addr t=%0d", t), 32'(a_addr), 32'(e_addr));
        end
    endtask

    task automatic launch(input int wb, input int ab, input int len);
        cfg_w_base = ADDR_W'(wb);
        cfg_a_base = ADDR_W'(ab);
        cfg_a_len  = LEN_W'(len);
        start      = 1'b1;
    endtask

    task automatic run_cycles(input int wb, input int ab, input int len,
                              input int first, input int last);
        for (int t = first; t <= last; t++) begin
            @(negedge clk);
            check_cycle(t, wb, ab, len);
            if (t == 1 && !hold_start) begin
                start      = 1'b0;
                cfg_w_base = ~cfg_w_base;
                cfg_a_base = ~cfg_a_base;
                cfg_a_len  = cfg_a_len + LEN_W'(3);
            end
        end
    endtask

    task automatic full_pass(input int wb, input int ab, input int len);
        launch(wb, ab, len);
        run_cycles(wb, ab, len, 1, COL + 1 + len + ROW + COL + 2);
        exp_perf += len;
        check("perf_cnt after pass", perf_cnt, PERF_EN ? 32'(exp_perf) : 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_w_base = '0;
        cfg_a_base = '0;
        cfg_a_len  = '0;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        // Nominal pass: done 30 cycles after acceptance.
        full_pass(16, 100, 4);
        // Empty execute phase with wrapping weight addresses: done after 26.
        full_pass(2046, 100, 0);

        // Abort on the third EXEC cycle.
        launch(16, 100, 4);
        run_cycles(16, 100, 4, 1, COL + 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_perf += 3;
        check("abort busy",     32'(busy),     32'd0);
        check("abort done",     32'(done),     32'd0);
        check("abort inst_row", 32'(inst_row), 32'd0);
        check("abort w_cen",    32'(w_cen),    32'd1);
        check("abort a_cen",    32'(a_cen),    32'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post-abort done", 32'(done), 32'd0);
            check("post-abort busy", 32'(busy), 32'd0);
        end
        check("perf_cnt after abort", perf_cnt, PERF_EN ? 32'(exp_perf) : 32'd0);
        full_pass(40, 300, 3);

        // Start held high: no re-acceptance while busy or on DONE.
        hold_start = 1'b1;
        launch(16, 100, 4);
        run_cycles(16, 100, 4, 1, 31);
        run_cycles(16, 100, 4, 1, 4);
        reset = 1'b0;
        #1;
        exp_perf = 0;
        check_reset_values("mid-load reset");
        #2;
        reset = 1'b1;
        hold_start = 1'b0;
        run_cycles(16, 100, 4, 1, 31);

        // Two back-to-back passes after a fresh reset: 4 + 5 EXEC cycles.
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        exp_perf = 0;
        full_pass(16, 100, 4);
        full_pass(16, 100, 5);
        check("perf_cnt two passes", perf_cnt, PERF_EN ? 32'd9 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
Sequencer for the systolic MAC array built from mac_row instances. Runs one tile pass per start pulse:
- kernel (weight) load phase;
- activation execute phase;
- drain phase.

It drives SRAM read strobes and addresses, and generates the per-row 3-bit instruction bus with one cycle of skew per row. It sits between the top-level core FSM and the PE array plus its weight/activation SRAMs.

Parameters:
row, 8, number of mac_row instances driven
col, 8, MAC tiles per row; kernel load length in cycles
addr_w, 11, SRAM address width
len_w, 8, width of activation-vector count

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin pass; sampled only in IDLE
abort  input  1  synchronous abort, any state
cfg_w_base  input  addr_w  first weight SRAM address
cfg_a_base  input  addr_w  first activation SRAM address
cfg_a_len  input  len_w  number of activation vectors (0 allowed)
w_cen  output  1  weight SRAM chip enable, active-low
w_addr  output  addr_w  weight SRAM read address
a_cen  output  1  activation SRAM chip enable, active-low
a_addr  output  addr_w  activation SRAM read address
inst_row  output  3*row  row r instruction at bits [3r+2:3r]; bit0 kernel load, bit1 execute, bit2 reserved (0)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on pass completion
perf_cnt  output  32  execute-cycle counter (see Optional Feature)

Behaviour:
- Reset (reset=0), effective immediately:
  - state=IDLE; w_cen=a_cen=1; w_addr=a_addr=0; inst_row=0; busy=0; done=0; perf_cnt=0.
  - All skew registers cleared.
- cfg_* are latched on the cycle start is accepted. Later changes have no effect on the pass.
- States: IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
- IDLE:
  - start=1 → LOAD; w_addr=cfg_w_base, load counter=0.
  - start=0 → stay.
- LOAD, exactly col cycles:
  - w_cen=0; w_addr increments by 1 each cycle, from base to base+col-1.
  - Then → GAP.
- GAP: 1 cycle; all cen=1.
  - cfg_a_len=0 → DRAIN.
  - Otherwise → EXEC; a_addr=cfg_a_base.
- EXEC, exactly cfg_a_len cycles:
  - a_cen=0; a_addr increments from base to base+len-1.
  - Then → DRAIN.
- DRAIN: row+col cycles, all cen=1, lets the skewed pipeline empty. Then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Base instruction inst0, registered, aligned with 1-cycle SRAM read latency:
  - bit0=1 in the cycle after each LOAD cycle.
  - bit1=1 in the cycle after each EXEC cycle.
  - Otherwise inst0=0.
- Row skew: row 0 gets inst0; row r gets row r-1's value delayed 1 cycle (shift register chain).
- Therefore row r instruction bits for a given SRAM read appear 1+r cycles after the corresponding cen=0 cycle.
- Address arithmetic wraps modulo 2^addr_w (e.g. base 2046, col 8 → 2046,2047,0,...,5).
- abort=1, any state:
  - Next cycle: IDLE; cen=1; inst0 and all skew stages cleared to 0; done not asserted.
  - Has priority over start. Abort in IDLE is a no-op.
- start while busy: ignored, not queued.
- start on the DONE cycle: ignored. Accepted earliest on the following IDLE cycle.
- Total pass length from start acceptance to done pulse: col+1+len+row+col+1 cycles. Defaults with len=4: 30 cycles; busy high for all 30.

Optional Feature:
Macro MAC_CTRL_PERF_CNT_EN.
- Defined:
  - perf_cnt increments by 1 on every cycle in EXEC, saturating at 2^32-1.
  - Cleared on reset only; not cleared by start or abort.
- Undefined: perf_cnt tied to 0 and no counter is synthesized.

Test Plan:
- Defaults; cfg_w_base=16, cfg_a_base=100, cfg_a_len=4; pulse start → required response:
  - w_addr 16..23 with w_cen=0 for 8 cycles; 1 gap cycle; a_addr 100..103 with a_cen=0.
  - inst_row[2:0]=001 for 8 cycles starting 1 cycle after the first w_cen=0.
  - inst_row[23:21] lags row 0 by 7 cycles.
  - done pulse exactly 30 cycles after start; busy high for those 30 cycles.
- cfg_a_len=0 → a_cen stays 1; no execute bit on any row; done 26 cycles after start.
- cfg_w_base=2046 → w_addr sequence 2046,2047,0,1,2,3,4,5.
- abort asserted on the 3rd EXEC cycle → next cycle state IDLE, busy=0, inst_row=0, no done pulse; then a new start runs a full correct pass.
- start held high through a pass; reset (reset=0) pulsed mid-LOAD → reset: all outputs immediately return to reset values. Pass behaviour:
  - Without reset: a second pass begins only after IDLE is re-entered; the held start is not accepted while busy or on DONE.
  - After reset is released: start is accepted in IDLE.
- With MAC_CTRL_PERF_CNT_EN defined, two passes with len=4 and len=5 → perf_cnt=9. Without the macro → perf_cnt=0 throughout.
